ttt_turn_ctrl: RTL and testbench
================================

Name: ttt_turn_ctrl

Overview:
- Game-sequencing controller for the 3x3 tic-tac-toe board register.
- Turns raw push-buttons into a cursor position, a player select and a one-cycle place strobe for the board.
- Reads the board back to detect win or draw, and enforces a per-turn timeout by auto-placing.
- Sits between the button/debounce inputs and the board; its status outputs drive the display logic.

Parameters:
- TURN_TICKS, 500_000_000: clk cycles allowed per turn before auto-place (10 s at 50 MHz).
- TIMER_W, 29: turn-timer width; must satisfy 2^TIMER_W > TURN_TICKS.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_move  in  1  raw cursor-advance button, asynchronous to clk.
- btn_place  in  1  raw place/restart button, asynchronous to clk.
- board  in  [8:0][1:0]  current board. Cell codes: 00 empty, 01 X, 10 O.
- pos  out  4  cursor cell index, 0..8.
- player  out  1  side to move: 1 = X, 0 = O.
- place  out  1  one-cycle strobe; board writes the player's mark at pos.
- board_clr  out  1  one-cycle strobe; clears the board on restart.
- illegal  out  1  one-cycle pulse when placement on an occupied cell is attempted.
- winner  out  2  00 none, 01 X won, 10 O won, 11 draw.
- game_over  out  1  high while in OVER state.
- time_left  out  TIMER_W  TURN_TICKS-1 minus elapsed ticks in the current turn.

Behaviour:
- Input conditioning:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detector.
  - Each event is a single-cycle pulse, 3 cycles after the synchronous edge.
  - Level held high produces exactly one event.
- Reset values: pos=0, player=1 (X moves first), place=0, board_clr=0, illegal=0, winner=00, game_over=0, timer=0, state=TURN, synchronizer flops=0.
- States:
  - TURN: timer counts each cycle.
    - move event: pos=(pos==8)?0:pos+1.
    - place event with board[pos]==00: assert place for 1 cycle, go to SETTLE.
    - place event with board[pos]!=00: pulse illegal, stay in TURN, timer unaffected.
    - timer==TURN_TICKS-1: pos = lowest-index empty cell, assert place, go to SETTLE. TURN is only entered with at least one empty cell.
    - move and place events in the same cycle: place wins; move is dropped.
  - SETTLE: one cycle; the board absorbs the write. pos and player are held constant from the place cycle through CHECK.
  - CHECK: evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) against the code of player (X=01, O=10).
    - Line match: winner=that code, go to OVER.
    - Else all 9 cells non-zero: winner=11, go to OVER.
    - Else: player toggles, timer=0, go to TURN. pos is kept.
  - OVER: game_over=1, timer frozen, move events ignored.
    - place event: pulse board_clr, winner=00, player=1, pos=0, timer=0, go to TURN.
- Timing:
  - Placement completes in 3 cycles: place, SETTLE, CHECK.
  - Next TURN is on cycle 4.
  - Button events arriving during SETTLE or CHECK are dropped.
- Timer: saturates by construction; it never exceeds TURN_TICKS-1. time_left is derived combinationally.
- Async reset mid-operation: all state returns to reset values immediately. Any in-flight place strobe deasserts.
- The controller never writes to a non-empty cell. The board's own occupancy guard is redundant, not relied upon.

Decomposition:
- Package ttt_pkg:
  - cell_t codes (EMPTY=2'b00, X=2'b01, O=2'b10), winner codes incl. DRAW=2'b11.
  - board_t as [8:0][1:0].
  - ctrl_state_t enum {TURN, SETTLE, CHECK, OVER}.
  - Constant table of the 8 winning index triples.
- Sub-module btn_edge_sync (2-FF sync + rising-edge pulse), instantiated twice.
- Win/draw evaluation and first-empty search stay as combinational functions in the package.

Test Plan:
- Reset then 3 move events -> pos=3, player=1, winner=00, game_over=0.
- Bench uses TURN_TICKS=20. Board from a board model; placements at 0,3,1,4,2 (X,O,X,O,X) -> each shows 1-cycle place with the correct player; after the 5th, winner=01, game_over=1.
- Place on occupied cell 4 -> illegal pulses 1 cycle, no place, player unchanged, timer keeps counting.
- Idle turn with cells 0,1 filled -> place asserts at cycle 20 of the turn with pos=2, player toggles after CHECK.
- Fill sequence 0,1,2,4,3,5,7,6,8 -> no line, winner=11 after the 9th placement; move event in OVER leaves pos unchanged.
- In OVER, place event -> board_clr 1 cycle, winner=00, player=1, pos=0. Assert rst during SETTLE -> place=0 and state=TURN immediately.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types, codes and board-evaluation helpers for the tic-tac-toe controller.
package ttt_pkg;

    typedef enum logic [1:0] {EMPTY = 2'b00, X = 2'b01, O = 2'b10} cell_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] DRAW     = 2'b11;

    typedef logic [8:0][1:0] board_t;

    typedef enum logic [1:0] {TURN, SETTLE, CHECK, OVER} ctrl_state_t;

    // Rows, columns, diagonals; cell order within a triple is irrelevant.
    localparam logic [7:0][2:0][3:0] WIN_LINES = {
        {4'd2, 4'd4, 4'd6}, {4'd0, 4'd4, 4'd8},
        {4'd2, 4'd5, 4'd8}, {4'd1, 4'd4, 4'd7}, {4'd0, 4'd3, 4'd6},
        {4'd6, 4'd7, 4'd8}, {4'd3, 4'd4, 4'd5}, {4'd0, 4'd1, 4'd2}
    };

    function automatic logic line_win(input board_t b, input logic [1:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (b[WIN_LINES[i][0]] == code && b[WIN_LINES[i][1]] == code &&
                b[WIN_LINES[i][2]] == code)
                hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic board_full(input board_t b);
        logic full;
        full = 1'b1;
        for (int i = 0; i < 9; i++)
            if (b[i] == EMPTY) full = 1'b0;
        return full;
    endfunction

    // Descending scan so the lowest empty index is the one left standing.
    function automatic logic [3:0] first_empty(input board_t b);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 8; i >= 0; i--)
            if (b[i] == EMPTY) idx = 4'(i);
        return idx;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for a raw button.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic evt
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s3  <= 1'b0;
            evt <= 1'b0;
        end else begin
            s1  <= btn;
            s2  <= s1;
            s3  <= s2;
            evt <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Turn sequencing for tic-tac-toe: cursor, placement strobes, turn timeout,
// and win/draw detection by reading the board back after each write.
module ttt_turn_ctrl
    import ttt_pkg::*;
#(
    parameter int TURN_TICKS = 500_000_000,
    parameter int TIMER_W    = 29
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_move,
    input  logic               btn_place,
    input  logic [8:0][1:0]    board,
    output logic [3:0]         pos,
    output logic               player,
    output logic               place,
    output logic               board_clr,
    output logic               illegal,
    output logic [1:0]         winner,
    output logic               game_over,
    output logic [TIMER_W-1:0] time_left
);

    localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(TURN_TICKS - 1);

    ctrl_state_t        state, nxt;
    logic [3:0]         pos_q;
    logic               player_q;
    logic [1:0]         winner_q;
    logic [TIMER_W-1:0] timer;
    logic               move_evt, place_evt;
    logic               cur_empty, timeout, do_place, do_auto, won, full;
    logic [1:0]         mark;

    btn_edge_sync u_move  (.clk(clk), .rst(rst), .btn(btn_move),  .evt(move_evt));
    btn_edge_sync u_place (.clk(clk), .rst(rst), .btn(btn_place), .evt(place_evt));

    assign cur_empty = (board[pos_q] == EMPTY);
    assign timeout   = (timer == LAST_TICK);
    assign mark      = player_q ? X : O;
    assign won       = line_win(board, mark);
    assign full      = board_full(board);
    // A legal press on the timeout cycle places at the cursor, not the fallback cell.
    assign do_place  = (state == TURN) && place_evt && cur_empty;
    assign do_auto   = (state == TURN) && timeout && !do_place;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TURN;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            TURN:    if (do_place || do_auto) nxt = SETTLE;
            SETTLE:  nxt = CHECK;
            CHECK:   nxt = (won || full) ? OVER : TURN;
            OVER:    if (place_evt) nxt = TURN;
            default: nxt = TURN;
        endcase
    end

    always_comb begin
        place     = do_place || do_auto;
        illegal   = (state == TURN) && place_evt && !cur_empty && !timeout;
        board_clr = (state == OVER) && place_evt;
        game_over = (state == OVER);
        pos       = do_auto ? first_empty(board) : pos_q;
        player    = player_q;
        winner    = winner_q;
        time_left = LAST_TICK - timer;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q    <= 4'd0;
            player_q <= 1'b1;
            winner_q <= WIN_NONE;
            timer    <= '0;
        end else begin
            case (state)
                TURN: begin
                    if (do_auto)
                        pos_q <= first_empty(board);
                    else if (move_evt && !place_evt)
                        pos_q <= (pos_q == 4'd8) ? 4'd0 : 4'(pos_q + 4'd1);
                    // Held on the placement cycle so it never passes LAST_TICK.
                    if (!(do_place || do_auto))
                        timer <= timer + 1'b1;
                end
                CHECK: begin
                    if (won)
                        winner_q <= mark;
                    else if (full)
                        winner_q <= DRAW;
                    else begin
                        player_q <= ~player_q;
                        timer    <= '0;
                    end
                end
                OVER: begin
                    if (place_evt) begin
                        winner_q <= WIN_NONE;
                        player_q <= 1'b1;
                        pos_q    <= 4'd0;
                        timer    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Bench for ttt_turn_ctrl: board model, placement scoreboard, scenario tasks.
module tb_ttt_turn_ctrl;
    import ttt_pkg::*;

    localparam int TT = 20;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_move, btn_place;
    board_t        board;
    logic [3:0]    pos;
    logic          player, place, board_clr, illegal, game_over;
    logic [1:0]    winner;
    logic [TW-1:0] time_left;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] pos;
        logic       player;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    ttt_turn_ctrl #(.TURN_TICKS(TT), .TIMER_W(TW)) dut (
        .clk(clk), .rst(rst), .btn_move(btn_move), .btn_place(btn_place),
        .board(board), .pos(pos), .player(player), .place(place),
        .board_clr(board_clr), .illegal(illegal), .winner(winner),
        .game_over(game_over), .time_left(time_left)
    );

    // Board register model driven by the controller's strobes.
    always @(posedge clk or posedge rst) begin
        if (rst)            board <= '0;
        else if (board_clr) board <= '0;
        else if (place)     board[pos] <= player ? 2'b01 : 2'b10;
    end

    // Scoreboard: every place cycle must match the next expected placement.
    always @(negedge clk) begin
        if (rst === 1'b0 && place === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL place_unexpected: got pos=%0d player=%0d, want no place", pos, player);
            end else begin
                mon_e = exp_q.pop_front();
                if (pos !== mon_e.pos || player !== mon_e.player) begin
                    n_err++;
                    $display("FAIL place: got pos=%0d player=%0d, want pos=%0d player=%0d",
                             pos, player, mon_e.pos, mon_e.player);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Event becomes visible on the tick this task returns.
    task automatic press(input bit plc);
        if (plc) btn_place = 1'b1;
        else     btn_move  = 1'b1;
        tick();
        btn_place = 1'b0;
        btn_move  = 1'b0;
        tick();
        tick();
    endtask

    task automatic moves(input int n);
        for (int i = 0; i < n; i++) press(1'b0);
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d placements outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic turn(input int nmv, input logic [3:0] p, input logic pl);
        moves(nmv);
        exp_q.push_back('{pos: p, player: pl});
        press(1'b1);
        drain(8);
        repeat (3) tick();
    endtask

    task automatic auto_turn(input logic [3:0] p, input logic pl);
        exp_q.push_back('{pos: p, player: pl});
        drain(40);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_move = 1'b0; btn_place = 1'b0;
        repeat (2) tick();
        n_vec++;
        if ({pos, player, place, board_clr, illegal, winner, game_over} !==
            {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, want %h",
                     {pos, player, place, board_clr, illegal, winner, game_over},
                     {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
        end
        n_vec++;
        if (time_left !== TW'(TT - 1)) begin
            n_err++; $display("FAIL reset_time_left: got %0d, want %0d", time_left, TT - 1);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (time_left !== TW'(TT - 2)) begin
            n_err++; $display("FAIL timer_runs: got %0d, want %0d", time_left, TT - 2);
        end
    endtask

    task automatic test_move();
        moves(3);
        tick();
        n_vec++;
        if ({pos, player, winner, game_over} !== {4'd3, 1'b1, 2'b00, 1'b0}) begin
            n_err++;
            $display("FAIL move3: got pos=%0d player=%0d winner=%0d over=%0d, want 3 1 0 0",
                     pos, player, winner, game_over);
        end
    endtask

    task automatic test_game_win();
        rst = 1'b1; tick(); rst = 1'b0;
        turn(0, 4'd0, 1'b1);
        turn(3, 4'd3, 1'b0);
        auto_turn(4'd1, 1'b1);
        turn(3, 4'd4, 1'b0);
    endtask

    task automatic test_illegal();
        int tl, cnt;
        tl  = time_left;
        cnt = 0;
        press(1'b1);
        for (int i = 0; i < 4; i++) begin
            cnt += illegal;
            tick();
        end
        n_vec++;
        if (cnt != 1) begin
            n_err++; $display("FAIL illegal_pulse: got %0d cycles, want 1", cnt);
        end
        n_vec++;
        if (player !== 1'b1 || pos !== 4'd4) begin
            n_err++; $display("FAIL illegal_hold: got player=%0d pos=%0d, want 1 4", player, pos);
        end
        n_vec++;
        if (int'(time_left) != tl - 7) begin
            n_err++; $display("FAIL illegal_timer: got %0d, want %0d", time_left, tl - 7);
        end
        auto_turn(4'd2, 1'b1);
    endtask

    task automatic test_win_result();
        n_vec++;
        if (winner !== 2'b01 || game_over !== 1'b1) begin
            n_err++; $display("FAIL win: got winner=%0d over=%0d, want 1 1", winner, game_over);
        end
    endtask

    task automatic test_restart();
        int cnt;
        cnt = 0;
        press(1'b1);
        for (int i = 0; i < 4; i++) begin
            cnt += board_clr;
            tick();
        end
        n_vec++;
        if (cnt != 1) begin
            n_err++; $display("FAIL board_clr_pulse: got %0d cycles, want 1", cnt);
        end
        n_vec++;
        if ({winner, player, pos, game_over} !== {2'b00, 1'b1, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL restart: got winner=%0d player=%0d pos=%0d over=%0d, want 0 1 0 0",
                     winner, player, pos, game_over);
        end
    endtask

    task automatic test_timeout_draw();
        int cnt;
        turn(0, 4'd0, 1'b1);
        turn(1, 4'd1, 1'b0);
        n_vec++;
        if (time_left !== TW'(TT - 1)) begin
            n_err++; $display("FAIL turn_start_timer: got %0d, want %0d", time_left, TT - 1);
        end
        exp_q.push_back('{pos: 4'd2, player: 1'b1});
        cnt = 0;
        while (!place && cnt < 40) begin
            tick();
            cnt++;
        end
        n_vec++;
        if (cnt != TT - 1) begin
            n_err++; $display("FAIL timeout_cycle: got place after %0d cycles, want %0d", cnt, TT - 1);
        end
        repeat (3) tick();
        n_vec++;
        if (player !== 1'b0 || pos !== 4'd2) begin
            n_err++; $display("FAIL timeout_toggle: got player=%0d pos=%0d, want 0 2", player, pos);
        end
        turn(2, 4'd4, 1'b0);
        auto_turn(4'd3, 1'b1);
        turn(2, 4'd5, 1'b0);
        turn(2, 4'd7, 1'b1);
        auto_turn(4'd6, 1'b0);
        n_vec++;
        if (winner !== 2'b00 || game_over !== 1'b0) begin
            n_err++; $display("FAIL no_early_end: got winner=%0d over=%0d, want 0 0", winner, game_over);
        end
        turn(2, 4'd8, 1'b1);
        n_vec++;
        if (winner !== 2'b11 || game_over !== 1'b1) begin
            n_err++; $display("FAIL draw: got winner=%0d over=%0d, want 3 1", winner, game_over);
        end
    endtask

    task automatic test_over_move();
        press(1'b0);
        repeat (2) tick();
        n_vec++;
        if (pos !== 4'd8 || game_over !== 1'b1 || winner !== 2'b11) begin
            n_err++;
            $display("FAIL over_move: got pos=%0d over=%0d winner=%0d, want 8 1 3", pos, game_over, winner);
        end
    endtask

    task automatic test_rst_settle();
        press(1'b1);
        repeat (3) tick();
        exp_q.push_back('{pos: 4'd0, player: 1'b1});
        press(1'b1);
        tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({place, pos, player, winner, game_over} !== {1'b0, 4'd0, 1'b1, 2'b00, 1'b0}) begin
            n_err++;
            $display("FAIL rst_settle: got place=%0d pos=%0d player=%0d winner=%0d over=%0d, want 0 0 1 0 0",
                     place, pos, player, winner, game_over);
        end
        n_vec++;
        if (time_left !== TW'(TT - 1)) begin
            n_err++; $display("FAIL rst_settle_timer: got %0d, want %0d", time_left, TT - 1);
        end
        tick();
        rst = 1'b0;
        repeat (2) tick();
        n_vec++;
        if (time_left !== TW'(TT - 3)) begin
            n_err++; $display("FAIL rst_turn_counts: got %0d, want %0d", time_left, TT - 3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_move();
        test_game_win();
        test_illegal();
        test_win_result();
        test_restart();
        test_timeout_draw();
        test_over_move();
        test_rst_settle();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_left: got %0d, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
